// File: rtl/fpu_fmul.sv
// rtl/fpu_fmul.sv - multi-cycle IEEE-754 single-precision multiplier
//
// Purpose: radix-2 shift-add multiply of the 24-bit significands, then
// normalise, round-to-nearest-even and pack. Denormals flush to zero and
// no exception flags are produced.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst      in   1  asynchronous active-high reset
//   do_fmul  in   1  one-cycle start pulse, sampled only in IDLE
//   a        in  32  multiplicand (IEEE-754 single)
//   b        in  32  multiplier (IEEE-754 single)
//   q        out 32  result, held until the next operation's NORM
//   valid    out  1  one-cycle completion pulse
//   busy     out  1  high in every state except IDLE
module fpu_fmul (
  input  logic        clk,
  input  logic        rst,
  input  logic        do_fmul,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q,
  output logic        valid,
  output logic        busy
);

  localparam int MUL_CYCLES = 24;

  typedef enum logic [1:0] {S_IDLE, S_UNPACK, S_MUL, S_NORM} state_t;

  state_t       state_q, state_d;
  logic         sign_q, sign_d;
  logic [7:0]   ea_q, ea_d;
  logic [7:0]   eb_q, eb_d;
  logic [23:0]  mcand_q, mcand_d;
  logic [23:0]  mplier_q, mplier_d;
  logic [47:0]  acc_q, acc_d;
  logic [4:0]   cnt_q, cnt_d;
  logic         special_q, special_d;
  logic [31:0]  spec_res_q, spec_res_d;
  logic [31:0]  q_q, q_d;
  logic         valid_q, valid_d;

  // Operand classification, evaluated on the raw inputs at start time
  logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, s_in;
  logic        spec_hit;
  logic [31:0] spec_val;

  always_comb begin
    a_zero   = (a[30:23] == 8'd0);
    b_zero   = (b[30:23] == 8'd0);
    a_inf    = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf    = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan    = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan    = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    s_in     = a[31] ^ b[31];
    spec_hit = 1'b1;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      spec_val = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      spec_val = {s_in, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      spec_val = {s_in, 31'd0};
    end else begin
      spec_val = 32'd0;
      spec_hit = 1'b0;
    end
  end

  // One shift-add step: add into the upper half, keep the carry, shift right
  logic [24:0] add_sum;

  always_comb begin
    add_sum = {1'b0, acc_q[47:24]} + (mplier_q[0] ? {1'b0, mcand_q} : 25'd0);
  end

  // Normalise, round and pack the finished product
  logic signed [9:0] e_base, e_norm, e_fin;
  logic [22:0]       mant_pre, mant_fin;
  logic [23:0]       mant_rnd;
  logic              guard, sticky, round_up;
  logic [31:0]       packed_res;

  always_comb begin
    e_base = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - 10'sd127;
    if (acc_q[47]) begin
      mant_pre = acc_q[46:24];
      guard    = acc_q[23];
      sticky   = |acc_q[22:0];
      e_norm   = e_base + 10'sd1;
    end else begin
      mant_pre = acc_q[45:23];
      guard    = acc_q[22];
      sticky   = |acc_q[21:0];
      e_norm   = e_base;
    end
    round_up = guard & (sticky | mant_pre[0]);
    mant_rnd = {1'b0, mant_pre} + {23'd0, round_up};
    // Carry out of the fraction means 1.111..1 rounded up to 10.000..0
    if (mant_rnd[23]) begin
      mant_fin = 23'd0;
      e_fin    = e_norm + 10'sd1;
    end else begin
      mant_fin = mant_rnd[22:0];
      e_fin    = e_norm;
    end
    if (e_fin >= 10'sd255) begin
      packed_res = {sign_q, 8'hFF, 23'd0};
    end else if (e_fin <= 10'sd0) begin
      packed_res = {sign_q, 31'd0};
    end else begin
      packed_res = {sign_q, e_fin[7:0], mant_fin};
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (do_fmul) state_d = S_UNPACK;
      S_UNPACK: state_d = special_q ? S_NORM : S_MUL;
      S_MUL:    if (cnt_q == 5'(MUL_CYCLES - 1)) state_d = S_NORM;
      S_NORM:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy  = (state_q != S_IDLE);
    valid = valid_q;
    q     = q_q;
  end

  // Datapath next values
  always_comb begin
    sign_d     = sign_q;
    ea_d       = ea_q;
    eb_d       = eb_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    q_d        = q_q;
    valid_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (do_fmul) begin
          sign_d     = s_in;
          ea_d       = a[30:23];
          eb_d       = b[30:23];
          mcand_d    = {1'b1, a[22:0]};
          mplier_d   = {1'b1, b[22:0]};
          special_d  = spec_hit;
          spec_res_d = spec_val;
        end
      end
      S_UNPACK: begin
        cnt_d = 5'd0;
        acc_d = 48'd0;
      end
      S_MUL: begin
        acc_d    = {add_sum, acc_q[23:1]};
        mplier_d = {1'b0, mplier_q[23:1]};
        cnt_d    = cnt_q + 5'd1;
      end
      S_NORM: begin
        q_d     = special_q ? spec_res_q : packed_res;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q     <= 1'b0;
      ea_q       <= 8'd0;
      eb_q       <= 8'd0;
      mcand_q    <= 24'd0;
      mplier_q   <= 24'd0;
      acc_q      <= 48'd0;
      cnt_q      <= 5'd0;
      special_q  <= 1'b0;
      spec_res_q <= 32'd0;
      q_q        <= 32'd0;
      valid_q    <= 1'b0;
    end else begin
      sign_q     <= sign_d;
      ea_q       <= ea_d;
      eb_q       <= eb_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      q_q        <= q_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: tb/tb_fpu_fmul.sv
// tb/tb_fpu_fmul.sv - scoreboard bench for fpu_fmul against an arithmetic reference model
module tb_fpu_fmul;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        do_fmul = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] q;
  logic        valid;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t sb[$];

  fpu_fmul dut (
    .clk     (clk),
    .rst     (rst),
    .do_fmul (do_fmul),
    .a       (a),
    .b       (b),
    .q       (q),
    .valid   (valid),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit is_special(input logic [31:0] x, input logic [31:0] y);
    return (x[30:23] == 8'd0) || (x[30:23] == 8'hFF) ||
           (y[30:23] == 8'd0) || (y[30:23] == 8'hFF);
  endfunction

  // Reference: exact integer product, then round-to-nearest-even by remainder compare
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    int     ex, ey, e, sh;
    longint mx, my, p, m, r, half;
    bit     s, xz, yz, xi, yi, xn, yn;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = longint'(x[22:0]);
    my = longint'(y[22:0]);
    s  = x[31] ^ y[31];
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (mx == 0);
    yi = (ey == 255) && (my == 0);
    xn = (ex == 255) && (mx != 0);
    yn = (ey == 255) && (my != 0);
    if (xn || yn || (xi && yz) || (yi && xz)) return 32'h7FC0_0000;
    if (xi || yi) return {s, 8'hFF, 23'd0};
    if (xz || yz) return {s, 31'd0};
    p    = (mx + 64'd8388608) * (my + 64'd8388608);
    sh   = (p >= (64'd1 << 47)) ? 24 : 23;
    e    = ex + ey - 127 + (sh - 23);
    m    = p >> sh;
    r    = p - (m << sh);
    half = 64'd1 << (sh - 1);
    if (r > half || (r == half && (m % 2) == 1)) m = m + 1;
    if (m == (64'd1 << 24)) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, 8'(e), 23'(m)};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [7:0]  ex;
    logic [22:0] mt;
    int          sel;
    sel = $urandom_range(0, 15);
    case (sel)
      0:       ex = 8'd0;
      1:       ex = 8'hFF;
      2, 3:    ex = 8'($urandom_range(1, 3));
      4, 5:    ex = 8'($urandom_range(250, 254));
      default: ex = 8'($urandom_range(64, 190));
    endcase
    mt = ($urandom_range(0, 7) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom), ex, mt};
  endfunction

  // Caller must be positioned at a negedge; returns at the negedge after the sampling edge
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_in);
    exp_t e;
    a       = ta;
    b       = tb_in;
    do_fmul = 1'b1;
    @(posedge clk);
    #1;
    e.res = ref_mul(ta, tb_in);
    e.due = cyc + (is_special(ta, tb_in) ? 2 : 26);
    sb.push_back(e);
    @(negedge clk);
    do_fmul = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL timeout busy=%0b pending=%0d required idle with 0 pending", busy, sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL spurious_valid q=%08h at cycle %0d required no valid", q, cyc);
      end else begin
        e = sb.pop_front();
        if (q !== e.res) begin
          errors++;
          $display("FAIL result q=%08h required %08h", q, e.res);
        end
        checks++;
        if (cyc != e.due) begin
          errors++;
          $display("FAIL latency cycle=%0d required %0d", cyc, e.due);
        end
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_valid busy=%0b required 0", busy);
        end
      end
    end
  end

  logic [31:0] dir_a [9];
  logic [31:0] dir_b [9];
  logic [31:0] prev;

  initial begin
    dir_a = '{32'h4000_0000, 32'h3FC0_0000, 32'h3F80_0001, 32'h8000_0000, 32'h7F80_0000,
              32'h7F00_0000, 32'h0080_0000, 32'h7FC1_2345, 32'hFF80_0000};
    dir_b = '{32'h4040_0000, 32'hBFC0_0000, 32'h3F80_0001, 32'h3F80_0000, 32'h0000_0000,
              32'h4000_0000, 32'h3F00_0000, 32'h3F80_0000, 32'h4000_0000};

    #1;
    checks++;
    if (valid !== 1'b0 || q !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state valid=%0b q=%08h busy=%0b required 0/00000000/0", valid, q, busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases, including the test-plan values
    for (int i = 0; i < 9; i++) begin
      issue(dir_a[i], dir_b[i]);
      wait_done();
      @(negedge clk);
    end

    // Known-answer checks independent of the model
    issue(32'h4000_0000, 32'h4040_0000);
    wait_done();
    checks++;
    if (q !== 32'h40C0_0000) begin
      errors++;
      $display("FAIL kat_2x3 q=%08h required 40c00000", q);
    end
    issue(32'h3F80_0001, 32'h3F80_0001);
    wait_done();
    checks++;
    if (q !== 32'h3F80_0002) begin
      errors++;
      $display("FAIL kat_sticky q=%08h required 3f800002", q);
    end
    @(negedge clk);

    // Start pulse during MUL must be ignored
    issue(32'h4000_0000, 32'h4040_0000);
    repeat (3) @(negedge clk);
    a       = 32'h4100_0000;
    b       = 32'h4100_0000;
    do_fmul = 1'b1;
    @(negedge clk);
    do_fmul = 1'b0;
    wait_done();
    repeat (30) @(negedge clk);

    // New start coinciding with valid: q keeps the old result until the new NORM
    issue(32'h3FC0_0000, 32'hBFC0_0000);
    prev = ref_mul(32'h3FC0_0000, 32'hBFC0_0000);
    begin
      int n;
      n = 0;
      while (!valid && n < 60) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (!valid) begin
        errors++;
        $display("FAIL overlap_valid_wait valid=%0b required 1", valid);
      end
    end
    issue(32'h4000_0000, 32'h4040_0000);
    repeat (5) @(negedge clk);
    checks++;
    if (q !== prev) begin
      errors++;
      $display("FAIL overlap_hold q=%08h required %08h", q, prev);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL overlap_busy busy=%0b required 1", busy);
    end
    wait_done();
    @(negedge clk);

    // Reset mid-operation aborts with no valid pulse
    issue(32'h4000_0000, 32'h4040_0000);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0 || q !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset valid=%0b q=%08h busy=%0b required 0/00000000/0", valid, q, busy);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    issue(32'h3FC0_0000, 32'hBFC0_0000);
    wait_done();
    @(negedge clk);

    // Randomized operands
    for (int i = 0; i < 150; i++) begin
      issue(rnd_op(), rnd_op());
      wait_done();
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    repeat (30) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
